// File: rtl/spike_count_classifier.sv
`timescale 1ns/1ps
// Output-spike vote counter: pops neuron IDs from the spike FIFO, keeps saturating per-neuron
// counts, and on end-of-frame drains the FIFO then runs a serial argmax. Optional SPIKE_CNT_READBACK_EN.
module spike_count_classifier #(
  parameter int NUM_OUTPUTS = 10,
  parameter int COUNT_W     = 8,
  parameter int DRAIN_QUIET = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_pulse,
  input  logic               frame_done,
  input  logic               fifo_empty,
  input  logic [3:0]         fifo_rdata,
  output logic               fifo_pop,
  output logic               result_valid,
  output logic [3:0]         result_class,
  output logic [COUNT_W-1:0] result_count,
  output logic               result_none,
  output logic               busy,
  output logic               id_err,
  output logic               sat_err
`ifdef SPIKE_CNT_READBACK_EN
  ,
  input  logic [3:0]         cnt_rd_idx,
  output logic [COUNT_W-1:0] cnt_rd_data
`endif
);

  localparam int ID_W    = 4;
  localparam int QUIET_W = (DRAIN_QUIET > 1) ? $clog2(DRAIN_QUIET) : 1;
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(DRAIN_QUIET - 1);
  localparam logic [ID_W-1:0]    LAST_IDX   = ID_W'(NUM_OUTPUTS - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {ST_COUNT, ST_DRAIN, ST_SCAN, ST_DONE} state_t;

  // MSB of the return value flags that the counter was already pinned at full scale.
  function automatic logic [COUNT_W:0] sat_inc(input logic [COUNT_W-1:0] v);
    if (v == CNT_MAX) return {1'b1, v};
    return {1'b0, v + COUNT_W'(1)};
  endfunction

  state_t               state_q, state_d;
  logic [QUIET_W-1:0]   quiet_q, quiet_d;
  logic [ID_W-1:0]      idx_q, idx_d;
  logic [ID_W-1:0]      best_idx_q, best_idx_d;
  logic [COUNT_W-1:0]   best_cnt_q, best_cnt_d;
  logic [COUNT_W-1:0]   cnt_q [NUM_OUTPUTS];
  logic [COUNT_W-1:0]   cnt_d [NUM_OUTPUTS];
  logic                 result_valid_q, result_valid_d;
  logic [ID_W-1:0]      result_class_q, result_class_d;
  logic [COUNT_W-1:0]   result_count_q, result_count_d;
  logic                 result_none_q, result_none_d;
  logic                 id_err_q, id_err_d;
  logic                 sat_err_q, sat_err_d;

  logic                 pop_ok;
  logic                 id_ok;
  logic [COUNT_W-1:0]   pop_val;
  logic [COUNT_W:0]     pop_inc;
  logic [COUNT_W-1:0]   scan_val;
  logic                 scan_better;
  logic [ID_W-1:0]      best_idx_n;
  logic [COUNT_W-1:0]   best_cnt_n;

  // clear_pulse squashes the pop so the head entry stays in the FIFO for the next frame.
  assign pop_ok   = !fifo_empty && !clear_pulse &&
                    ((state_q == ST_COUNT) || (state_q == ST_DRAIN));
  assign fifo_pop = pop_ok && !rst;
  assign id_ok    = int'(fifo_rdata) < NUM_OUTPUTS;

  always_comb begin
    pop_val  = '0;
    scan_val = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (fifo_rdata == ID_W'(i)) pop_val = cnt_q[i];
      if (idx_q == ID_W'(i))      scan_val = cnt_q[i];
    end
  end

  assign pop_inc     = sat_inc(pop_val);
  assign scan_better = scan_val > best_cnt_q;
  assign best_idx_n  = scan_better ? idx_q : best_idx_q;
  assign best_cnt_n  = scan_better ? scan_val : best_cnt_q;

  always_comb begin
    state_d        = state_q;
    quiet_d        = quiet_q;
    idx_d          = idx_q;
    best_idx_d     = best_idx_q;
    best_cnt_d     = best_cnt_q;
    cnt_d          = cnt_q;
    result_valid_d = 1'b0;
    result_class_d = result_class_q;
    result_count_d = result_count_q;
    result_none_d  = result_none_q;
    id_err_d       = id_err_q;
    sat_err_d      = sat_err_q;

    if (clear_pulse) begin
      state_d        = ST_COUNT;
      quiet_d        = '0;
      idx_d          = '0;
      best_idx_d     = '0;
      best_cnt_d     = '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt_d[i] = '0;
      result_class_d = '0;
      result_count_d = '0;
      result_none_d  = 1'b0;
      id_err_d       = 1'b0;
      sat_err_d      = 1'b0;
    end else begin
      if (pop_ok) begin
        if (id_ok) begin
          for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (fifo_rdata == ID_W'(i)) cnt_d[i] = pop_inc[COUNT_W-1:0];
          end
          if (pop_inc[COUNT_W]) sat_err_d = 1'b1;
        end else begin
          id_err_d = 1'b1;
        end
      end

      unique case (state_q)
        ST_COUNT: begin
          if (frame_done) begin
            state_d = ST_DRAIN;
            quiet_d = '0;
          end
        end
        // Drain ends only after DRAIN_QUIET consecutive empty cycles; any late entry restarts the run.
        ST_DRAIN: begin
          if (fifo_empty) begin
            if (quiet_q == QUIET_LAST) begin
              state_d    = ST_SCAN;
              idx_d      = '0;
              best_idx_d = '0;
              best_cnt_d = '0;
            end else begin
              quiet_d = quiet_q + QUIET_W'(1);
            end
          end else begin
            quiet_d = '0;
          end
        end
        ST_SCAN: begin
          best_idx_d = best_idx_n;
          best_cnt_d = best_cnt_n;
          idx_d      = idx_q + ID_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d        = ST_DONE;
            result_valid_d = 1'b1;
            result_class_d = best_idx_n;
            result_count_d = best_cnt_n;
            result_none_d  = (best_cnt_n == '0);
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_COUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_COUNT;
      quiet_q        <= '0;
      idx_q          <= '0;
      best_idx_q     <= '0;
      best_cnt_q     <= '0;
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= '0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
      result_count_q <= '0;
      result_none_q  <= 1'b0;
      id_err_q       <= 1'b0;
      sat_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      quiet_q        <= quiet_d;
      idx_q          <= idx_d;
      best_idx_q     <= best_idx_d;
      best_cnt_q     <= best_cnt_d;
      cnt_q          <= cnt_d;
      result_valid_q <= result_valid_d;
      result_class_q <= result_class_d;
      result_count_q <= result_count_d;
      result_none_q  <= result_none_d;
      id_err_q       <= id_err_d;
      sat_err_q      <= sat_err_d;
    end
  end

  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign result_count = result_count_q;
  assign result_none  = result_none_q;
  assign id_err       = id_err_q;
  assign sat_err      = sat_err_q;
  assign busy         = (state_q == ST_DRAIN) || (state_q == ST_SCAN);

`ifdef SPIKE_CNT_READBACK_EN
  logic [COUNT_W-1:0] rd_data_d, rd_data_q;

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (cnt_rd_idx == ID_W'(i)) rd_data_d = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign cnt_rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_spike_count_classifier.sv
`timescale 1ns/1ps
// Randomised and directed bench for spike_count_classifier against a frame-level vote model.
module tb_spike_count_classifier;

  localparam int N    = 10;
  localparam int CW   = 8;
  localparam int DQ   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef enum {PH_COUNT, PH_DRAIN, PH_SCAN, PH_DONE} phase_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_pulse = 1'b0;
  logic          frame_done = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [3:0]    fifo_rdata = '0;
  logic          fifo_pop;
  logic          result_valid;
  logic [3:0]    result_class;
  logic [CW-1:0] result_count;
  logic          result_none;
  logic          busy;
  logic          id_err;
  logic          sat_err;
`ifdef SPIKE_CNT_READBACK_EN
  logic [3:0]    rd_idx = '0;
  logic [CW-1:0] rd_data;
`endif

  spike_count_classifier #(.NUM_OUTPUTS(N), .COUNT_W(CW), .DRAIN_QUIET(DQ)) dut (
    .clk(clk), .rst(rst), .clear_pulse(clear_pulse), .frame_done(frame_done),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_pop(fifo_pop),
    .result_valid(result_valid), .result_class(result_class), .result_count(result_count),
    .result_none(result_none), .busy(busy), .id_err(id_err), .sat_err(sat_err)
`ifdef SPIKE_CNT_READBACK_EN
    , .cnt_rd_idx(rd_idx), .cnt_rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_pop_cyc = 0;

  logic [3:0] fq[$];

  // Reference model state
  phase_t m_phase = PH_COUNT;
  int     m_cnt [N];
  int     m_empty_run = 0;
  int     m_scan_left = 0;
  bit     m_rv = 0;
  int     m_class = 0;
  int     m_count = 0;
  bit     m_none = 0;
  bit     m_id_err = 0;
  bit     m_sat_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_phase = PH_COUNT; m_rv = 0; m_class = 0; m_count = 0; m_none = 0;
    m_id_err = 0; m_sat_err = 0; m_empty_run = 0; m_scan_left = 0;
  endtask

  // Winner = highest count, lowest index among equals; zero when nothing was counted.
  task automatic model_finalize();
    int maxv;
    maxv = 0;
    foreach (m_cnt[i]) if (m_cnt[i] > maxv) maxv = m_cnt[i];
    m_class = 0;
    for (int i = N - 1; i >= 0; i--) if (m_cnt[i] == maxv) m_class = i;
    m_count = maxv;
    m_none  = (maxv == 0);
    m_rv    = 1;
  endtask

  task automatic model_edge(input bit rs, input bit clr, input bit fd, input bit emp,
                            input logic [3:0] rd, input bit pop);
    if (rs || clr) begin
      model_zero();
    end else begin
      m_rv = 0;
      if (pop) begin
        if (int'(rd) < N) begin
          if (m_cnt[rd] == CMAX) m_sat_err = 1;
          else m_cnt[rd] = m_cnt[rd] + 1;
        end else m_id_err = 1;
      end
      case (m_phase)
        PH_COUNT: if (fd) begin m_phase = PH_DRAIN; m_empty_run = 0; end
        PH_DRAIN: begin
          if (emp) begin
            m_empty_run++;
            if (m_empty_run == DQ) begin m_phase = PH_SCAN; m_scan_left = N; end
          end else m_empty_run = 0;
        end
        PH_SCAN: begin
          m_scan_left--;
          if (m_scan_left == 0) begin m_phase = PH_DONE; model_finalize(); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input bit fd, input bit clr, input bit rs);
    bit emp, exp_pop;
    logic [3:0] rd;
    emp = (fq.size() == 0);
    rd  = emp ? 4'($urandom_range(0, 15)) : fq[0];
    rst = rs; frame_done = fd; clear_pulse = clr; fifo_empty = emp; fifo_rdata = rd;
    #1;
    exp_pop = !rs && !clr && !emp && (m_phase == PH_COUNT || m_phase == PH_DRAIN);
    chk("fifo_pop", fifo_pop, exp_pop);
    @(posedge clk);
    cyc++;
    model_edge(rs, clr, fd, emp, rd, exp_pop);
    if (exp_pop) begin
      void'(fq.pop_front());
      last_pop_cyc = cyc;
    end
    #1;
    chk("result_valid", result_valid, m_rv);
    chk("busy", busy, (m_phase == PH_DRAIN || m_phase == PH_SCAN));
    chk("result_class", result_class, m_class);
    chk("result_count", result_count, m_count);
    chk("result_none", result_none, m_none);
    chk("id_err", id_err, m_id_err);
    chk("sat_err", sat_err, m_sat_err);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0);
  endtask

  task automatic wait_valid(input string tag, output int vcyc);
    vcyc = -1;
    for (int k = 0; k < 60; k++) begin
      cycle(0, 0, 0);
      if (result_valid === 1'b1) begin
        vcyc = cyc;
        break;
      end
    end
    chk({tag, "_valid_seen"}, (vcyc >= 0), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vc, nvalid;
    bit fd, clr, rs;

    // Reset with entries waiting: no pops while rst is high.
    fq.push_back(4'd1); fq.push_back(4'd2);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1);
    chk("reset_class", result_class, 0);
    chk("reset_valid", result_valid, 0);
    idle(3);
    cycle(0, 1, 0);

    // 3,3,7,3 back-to-back then frame_done; latency from last pop.
    fq.push_back(4'd3); fq.push_back(4'd3); fq.push_back(4'd7); fq.push_back(4'd3);
    idle(4);
    cycle(1, 0, 0);
    wait_valid("t1", vc);
    chk("t1_latency", vc - last_pop_cyc, DQ + N + 1);
    chk("t1_class", result_class, 3);
    chk("t1_count", result_count, 3);
    chk("t1_none", result_none, 0);
    idle(2);
    chk("t1_hold_class", result_class, 3);
    cycle(0, 1, 0);

    // Tie resolves to lowest index.
    fq.push_back(4'd5); fq.push_back(4'd1); fq.push_back(4'd5); fq.push_back(4'd1);
    idle(4);
    cycle(1, 0, 0);
    wait_valid("tie", vc);
    chk("tie_class", result_class, 1);
    chk("tie_count", result_count, 2);
    cycle(0, 1, 0);

    // Empty frame.
    cycle(1, 0, 0);
    wait_valid("empty", vc);
    chk("empty_class", result_class, 0);
    chk("empty_count", result_count, 0);
    chk("empty_none", result_none, 1);
    cycle(0, 1, 0);

    // Out-of-range ID.
    fq.push_back(4'd12); fq.push_back(4'd2);
    idle(2);
    cycle(1, 0, 0);
    wait_valid("iderr", vc);
    chk("iderr_flag", id_err, 1);
    chk("iderr_class", result_class, 2);
    chk("iderr_count", result_count, 1);
    cycle(0, 1, 0);
    chk("iderr_cleared", id_err, 0);

    // Saturation.
    for (int k = 0; k < CMAX + 5; k++) fq.push_back(4'd9);
    idle(CMAX + 5);
    cycle(1, 0, 0);
    wait_valid("sat", vc);
    chk("sat_count", result_count, CMAX);
    chk("sat_class", result_class, 9);
    chk("sat_flag", sat_err, 1);
    cycle(0, 1, 0);

    // Drain gap: a late entry restarts the quiet run and is still counted.
    fq.push_back(4'd4);
    idle(1);
    cycle(1, 0, 0);
    idle(3);
    fq.push_back(4'd4);
    wait_valid("gap", vc);
    chk("gap_class", result_class, 4);
    chk("gap_count", result_count, 2);
    cycle(0, 1, 0);

    // Clear in the fifth scan cycle aborts without a result.
    fq.push_back(4'd0);
    idle(1);
    cycle(1, 0, 0);
    idle(DQ);
    idle(4);
    cycle(0, 1, 0);
    chk("abort_busy", busy, 0);
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(0, 0, 0);
      if (result_valid === 1'b1) nvalid++;
    end
    chk("abort_no_valid", nvalid, 0);
    for (int k = 0; k < 6; k++) fq.push_back(4'd8);
    idle(6);
    cycle(1, 0, 0);
    wait_valid("after_abort", vc);
    chk("after_abort_class", result_class, 8);
    chk("after_abort_count", result_count, 6);
    cycle(0, 1, 0);

    // Random traffic with stray frame_done, clears and resets.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) == 0) fq.push_back(4'($urandom_range(10, 15)));
        else fq.push_back(4'($urandom_range(0, 9)));
      end
      fd  = ($urandom_range(0, 29) == 0);
      clr = (m_phase == PH_DONE && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
      rs  = ($urandom_range(0, 999) == 0);
      cycle(fd, clr, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
